// File: rtl/note_sequencer.sv
// note_sequencer: plays a stored note pattern at a programmable tempo, driving a clock scaler divisor and gate.
module note_sequencer #(
  parameter int STEPS = 8,
  parameter int TEMPO_W = 24,
  parameter int GAP = 16,
  localparam int AW = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [8:0]         wr_data,
  output logic [31:0]        scale_factor,
  output logic               gate,
  output logic [AW-1:0]      step,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
  localparam logic [16:0] BASE [12] = '{17'd95556, 17'd90194, 17'd85131, 17'd80353, 17'd75844, 17'd71586,
                                        17'd67568, 17'd63776, 17'd60196, 17'd56818, 17'd53629, 17'd50619};
  state_t state_q, state_d;
  logic [8:0] pat_q [STEPS];
  logic [8:0] pat_d [STEPS];
  logic [TEMPO_W-1:0] tempo_q, tempo_d, beat_q, beat_d;
  logic [1:0] len_q, len_d, len_cnt_q, len_cnt_d;
  logic rest_q, rest_d, done_q, done_d;
  logic [AW-1:0] step_q, step_d;
  logic [31:0] sf_q, sf_d;
  logic [8:0] ent;
  logic ent_rest, beat_end, step_end;
  logic [TEMPO_W+1:0] rem;
  always_comb begin
    ent = pat_q[step_q];
    ent_rest = ent[8] || ent[3:0] > 4'd11;
    beat_end = beat_q == tempo_q - TEMPO_W'(1);
    step_end = state_q == PLAY && beat_end && len_cnt_q == len_q;
    // cycles left in PLAY, including the current one
    rem = (TEMPO_W+2)'(len_q - len_cnt_q) * (TEMPO_W+2)'(tempo_q) + (TEMPO_W+2)'(tempo_q - beat_q);
    state_d = state_q;
    pat_d = pat_q;
    tempo_d = tempo_q;
    beat_d = beat_q;
    len_d = len_q;
    len_cnt_d = len_cnt_q;
    rest_d = rest_q;
    step_d = step_q;
    sf_d = sf_q;
    done_d = 1'b0;
    if (state_q == IDLE && wr_en) pat_d[wr_addr] = wr_data;
    if (stop) begin
      state_d = IDLE;
      step_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = LOAD;
          step_d = '0;
          tempo_d = tempo == '0 ? TEMPO_W'(1) : tempo;
        end
        LOAD: begin
          state_d = PLAY;
          beat_d = '0;
          len_cnt_d = '0;
          len_d = ent[5:4];
          rest_d = ent_rest;
          sf_d = ent_rest ? sf_q : 32'(BASE[ent[3:0]] >> ent[7:6]) - 32'd1;
        end
        PLAY: begin
          beat_d = beat_end ? '0 : beat_q + TEMPO_W'(1);
          len_cnt_d = beat_end ? len_cnt_q + 2'd1 : len_cnt_q;
          if (step_end) begin
            step_d = step_q + AW'(1);
            state_d = step_q == AW'(STEPS-1) && !loop ? IDLE : LOAD;
            done_d = step_q == AW'(STEPS-1) && !loop;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < STEPS; i++) pat_q[i] <= 9'h100;
      tempo_q <= '0;
      beat_q <= '0;
      len_q <= '0;
      len_cnt_q <= '0;
      rest_q <= 1'b1;
      step_q <= '0;
      sf_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      tempo_q <= tempo_d;
      beat_q <= beat_d;
      len_q <= len_d;
      len_cnt_q <= len_cnt_d;
      rest_q <= rest_d;
      step_q <= step_d;
      sf_q <= sf_d;
      done_q <= done_d;
    end
  end
  assign gate = state_q == PLAY && !rest_q && rem > (TEMPO_W+2)'(GAP);
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign step = step_q;
  assign scale_factor = sf_q;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed checks of note_sequencer playback, gating, looping, stop and write protection.
module tb_note_sequencer;
  logic clk = 0, rst = 1, start = 0, stop = 0, loop = 0, wr_en = 0;
  logic [23:0] tempo = '0;
  logic [2:0] wr_addr = '0, step;
  logic [8:0] wr_data = '0;
  logic [31:0] scale_factor;
  logic gate, busy, done, gate_seen;
  int vec = 0, errs = 0, dcnt;
  note_sequencer dut (.clk(clk), .rst(rst), .tempo(tempo), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .scale_factor(scale_factor), .gate(gate),
    .step(step), .busy(busy), .done(done));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [8:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic pulse_stop();
    stop = 1;
    tick();
    stop = 0;
  endtask
  initial begin
    ticks(2);
    rst = 0;
    chk("rst_sf", scale_factor, 0);
    chk("rst_gate", gate, 0);
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    // all-rest playback: tempo 2, 1 beat -> 3 cycles per step
    tempo = 2;
    pulse_start();
    chk("rest_busy", busy, 1);
    gate_seen = 0; dcnt = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      gate_seen |= gate;
      dcnt += int'(done);
    end
    chk("rest_gate", gate_seen, 0);
    chk("rest_done_cnt", dcnt, 1);
    chk("rest_done_now", done, 1);
    chk("rest_busy_end", busy, 0);
    tick();
    chk("rest_done_pulse", done, 0);
    // single A note, tempo 100
    wr(0, 9'h009);
    tempo = 100;
    pulse_start();
    chk("a_load_busy", busy, 1);
    chk("a_load_gate", gate, 0);
    tick();
    chk("a_sf", scale_factor, 56817);
    chk("a_gate_on", gate, 1);
    ticks(83);
    chk("a_gate_83", gate, 1);
    tick();
    chk("a_gate_84", gate, 0);
    for (int i = 0; i < 2000 && busy; i++) tick();
    chk("a_idle", busy, 0);
    chk("a_sf_held", scale_factor, 56817);
    // 8 notes, octave 1, 2 beats, tempo 64 -> 129 cycles per step
    for (int n = 0; n < 8; n++) wr(3'(n), {5'b0_01_01, 4'(n)});
    tempo = 64;
    pulse_start();
    tick();
    chk("p_sf0", scale_factor, 47777);
    ticks(387);
    chk("p_step3", step, 3);
    chk("p_sf3", scale_factor, 40175);
    chk("p_gate3", gate, 1);
    ticks(643);
    chk("p_done_early", done, 0);
    chk("p_busy_late", busy, 1);
    tick();
    chk("p_done", done, 1);
    chk("p_busy_fall", busy, 0);
    // looping, then clear loop mid second pass
    loop = 1;
    pulse_start();
    dcnt = 0;
    for (int i = 0; i < 1032; i++) begin
      tick();
      dcnt += int'(done);
    end
    chk("l_wrap_step", step, 0);
    chk("l_wrap_busy", busy, 1);
    chk("l_no_done", dcnt, 0);
    tick();
    chk("l_wrap_sf", scale_factor, 47777);
    ticks(500);
    loop = 0;
    ticks(530);
    chk("l_done_early", done, 0);
    chk("l_busy_late", busy, 1);
    tick();
    chk("l_done", done, 1);
    chk("l_busy_fall", busy, 0);
    // stop during step 2, with a write attempted while busy
    pulse_start();
    ticks(259);
    chk("s_step2", step, 2);
    chk("s_sf2", scale_factor, 42564);
    wr(5, 9'h100);
    pulse_stop();
    chk("s_busy", busy, 0);
    chk("s_gate", gate, 0);
    chk("s_step", step, 0);
    chk("s_done", done, 0);
    chk("s_sf_hold", scale_factor, 42564);
    pulse_start();
    ticks(646);
    chk("s_replay_step5", step, 5);
    chk("s_replay_sf5", scale_factor, 35792);
    chk("s_replay_gate5", gate, 1);
    pulse_stop();
    chk("s_replay_stop", busy, 0);
    // tempo 0 plays as tempo 1: 2 beats -> 3 cycles per step
    tempo = 0;
    pulse_start();
    tick();
    chk("t0_sf", scale_factor, 47777);
    chk("t0_gate", gate, 0);
    ticks(2);
    chk("t0_step1", step, 1);
    ticks(20);
    chk("t0_done_early", done, 0);
    tick();
    chk("t0_done", done, 1);
    // start and stop together
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    chk("ss_busy", busy, 0);
    tick();
    chk("ss_busy_next", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
